// File: rtl/md_unit_ctrl_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide controller.
// The EX side is the master; the controller owning HI/LO is the slave.
interface md_unit_ctrl_if;
   logic        StartE;
   logic [2:0]  MdOpE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        MfSelE;
   logic        BusyE;
   logic        DoneE;
   logic [31:0] HiE;
   logic [31:0] LoE;
   logic [31:0] MdResultE;

   modport master (
      output StartE, MdOpE, SrcAE, SrcBE, MfSelE,
      input  BusyE, DoneE, HiE, LoE, MdResultE
   );

   modport slave (
      input  StartE, MdOpE, SrcAE, SrcBE, MfSelE,
      output BusyE, DoneE, HiE, LoE, MdResultE
   );
endinterface

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the EX stage: computes the 64-bit result at the start
// edge, holds it pending for a fixed latency, then commits it to the HI/LO registers.
module md_unit_ctrl #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   md_unit_ctrl_if.slave md
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_d, done_q;

   // ------------------------------------------------------------------
   // Single-shot datapath on the operands present at the start edge
   // ------------------------------------------------------------------
   logic [31:0] op_a, op_b;
   logic signed [63:0] ext_a_s, ext_b_s;
   logic [63:0] prod_s, prod_u;
   logic        div_signed;
   logic [31:0] a_mag, b_mag;
   logic [31:0] div_num, div_den;
   logic [31:0] uq, ur;
   logic [31:0] quot, rem;
   logic [63:0] mul_res, div_res, op_res;

   assign op_a = md.SrcAE;
   assign op_b = md.SrcBE;

   always_comb begin
      ext_a_s = $signed({{32{op_a[31]}}, op_a});
      ext_b_s = $signed({{32{op_b[31]}}, op_b});
      prod_s  = 64'(ext_a_s * ext_b_s);
      prod_u  = {32'd0, op_a} * {32'd0, op_b};
      mul_res = (md.MdOpE == OP_MULT) ? prod_s : prod_u;
   end

   // One unsigned divider serves both DIV and DIVU; signed division works on
   // magnitudes and fixes the signs afterwards, which also makes
   // 0x80000000 / -1 fall out naturally as 0x80000000 rem 0.
   always_comb begin
      div_signed = (md.MdOpE == OP_DIV);
      a_mag      = op_a[31] ? (~op_a + 32'd1) : op_a;
      b_mag      = op_b[31] ? (~op_b + 32'd1) : op_b;
      div_num    = div_signed ? a_mag : op_a;
      div_den    = div_signed ? b_mag : op_b;
      if (div_den == 32'd0) begin
         div_den = 32'd1;
      end
      uq = div_num / div_den;
      ur = div_num % div_den;
      quot = uq;
      rem  = ur;
      if (div_signed) begin
         quot = (op_a[31] ^ op_b[31]) ? (~uq + 32'd1) : uq;
         rem  = op_a[31] ? (~ur + 32'd1) : ur;
      end
      if (op_b == 32'd0) begin
         div_res = {op_a, 32'hFFFF_FFFF};
      end else begin
         div_res = {rem, quot};
      end
   end

   assign op_res = ((md.MdOpE == OP_MULT) || (md.MdOpE == OP_MULTU)) ? mul_res : div_res;

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         S_IDLE: begin
            if (md.StartE) begin
               case (md.MdOpE)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     pend_hi_d = op_res[63:32];
                     pend_lo_d = op_res[31:0];
                     if ((md.MdOpE == OP_MULT) || (md.MdOpE == OP_MULTU)) begin
                        cnt_d = MUL_LOAD;
                     end else begin
                        cnt_d = DIV_LOAD;
                     end
                     // A single-cycle latency goes straight to the commit cycle.
                     state_d = (cnt_d == 5'd0) ? S_COMMIT : S_RUN;
                  end
                  OP_MTHI: hi_d = op_a;
                  OP_MTLO: lo_d = op_a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            // The counter reaches zero on entry to COMMIT, which is busy cycle N.
            cnt_d = cnt_q - 5'd1;
            if (cnt_q <= 5'd1) begin
               cnt_d   = 5'd0;
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            hi_d    = pend_hi_q;
            lo_d    = pend_lo_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_COMMIT);
   end

   assign md.BusyE     = busy_q;
   assign md.DoneE     = done_q;
   assign md.HiE       = hi_q;
   assign md.LoE       = lo_q;
   assign md.MdResultE = md.MfSelE ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed plus randomized bench for md_unit_ctrl; expected HI/LO come from plain
// 64-bit arithmetic and the timing from the fixed MUL/DIV latencies.
module tb_md_unit_ctrl;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   md_unit_ctrl_if md_if ();

   md_unit_ctrl #(
      .MUL_CYCLES (MUL_N),
      .DIV_CYCLES (DIV_N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (md_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural result {HI, LO} from MIPS rules using 64-bit integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub;
      logic [63:0]     q64, r64;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      ref_result = 64'd0;
      case (op)
         3'd1: ref_result = 64'(sa * sb);
         3'd2: ref_result = ua * ub;
         3'd3: begin
            if (b == 32'd0) begin
               ref_result = {a, 32'hFFFF_FFFF};
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               q64 = sq;
               r64 = sr;
               ref_result = {r64[31:0], q64[31:0]};
            end
         end
         3'd4: begin
            if (b == 32'd0) begin
               ref_result = {a, 32'hFFFF_FFFF};
            end else begin
               q64 = ua / ub;
               r64 = ua % ub;
               ref_result = {r64[31:0], q64[31:0]};
            end
         end
         default: ref_result = 64'd0;
      endcase
   endfunction

   // Issue one op at the next edge and follow it to completion.
   // inject: drive DIVU then MTHI 0xAAAA during busy cycles 2-3 (must be ignored).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
      logic [63:0] r;
      int          n;
      md_if.StartE = 1'b1;
      md_if.MdOpE  = op;
      md_if.SrcAE  = a;
      md_if.SrcBE  = b;
      @(posedge clk);
      @(negedge clk);
      md_if.StartE = 1'b0;
      md_if.SrcAE  = $urandom;
      md_if.SrcBE  = $urandom;
      if (op >= 3'd1 && op <= 3'd4) begin
         n = (op <= 3'd2) ? MUL_N : DIV_N;
         r = ref_result(op, a, b);
         for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("busy_c%0d", k), 32'(md_if.BusyE), 32'd1);
            check($sformatf("done_c%0d", k), 32'(md_if.DoneE), (k == n) ? 32'd1 : 32'd0);
            check($sformatf("hi_hold_c%0d", k), md_if.HiE, hi_m);
            check($sformatf("lo_hold_c%0d", k), md_if.LoE, lo_m);
            if (inject) begin
               if (k == 2) begin
                  md_if.StartE = 1'b1;
                  md_if.MdOpE  = 3'd4;
                  md_if.SrcAE  = 32'd77;
                  md_if.SrcBE  = 32'd3;
               end else if (k == 3) begin
                  md_if.StartE = 1'b1;
                  md_if.MdOpE  = 3'd5;
                  md_if.SrcAE  = 32'h0000_AAAA;
               end else if (k == 4) begin
                  md_if.StartE = 1'b0;
               end
            end
         end
         @(negedge clk);
         hi_m = r[63:32];
         lo_m = r[31:0];
      end else if (op == 3'd5) begin
         hi_m = a;
      end else if (op == 3'd6) begin
         lo_m = a;
      end
      check("busy_after", 32'(md_if.BusyE), 32'd0);
      check("done_after", 32'(md_if.DoneE), 32'd0);
      check("hi_after", md_if.HiE, hi_m);
      check("lo_after", md_if.LoE, lo_m);
      check("mdres_after", md_if.MdResultE, md_if.MfSelE ? hi_m : lo_m);
      $display("op=%0d a=%h b=%h -> HiE=%h LoE=%h", op, a, b, md_if.HiE, md_if.LoE);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      bit          saw_done;
      checks = 0;
      errors = 0;
      hi_m = 32'd0;
      lo_m = 32'd0;
      rst_n = 1'b0;
      md_if.StartE = 1'b0;
      md_if.MdOpE  = 3'd0;
      md_if.SrcAE  = 32'd0;
      md_if.SrcBE  = 32'd0;
      md_if.MfSelE = 1'b0;

      #2;
      check("rst_busy", 32'(md_if.BusyE), 32'd0);
      check("rst_done", 32'(md_if.DoneE), 32'd0);
      check("rst_hi", md_if.HiE, 32'd0);
      check("rst_lo", md_if.LoE, 32'd0);
      check("rst_mdres", md_if.MdResultE, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
      check("mult_hi_const", md_if.HiE, 32'hFFFF_FFFF);
      check("mult_lo_const", md_if.LoE, 32'hFFFF_FFFA);

      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_hi_const", md_if.HiE, 32'hFFFF_FFFE);
      check("multu_lo_const", md_if.LoE, 32'h0000_0001);
      md_if.MfSelE = 1'b1;
      #1 check("mfhi", md_if.MdResultE, 32'hFFFF_FFFE);
      md_if.MfSelE = 1'b0;
      #1 check("mflo", md_if.MdResultE, 32'h0000_0001);

      run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      check("div_lo_const", md_if.LoE, 32'hFFFF_FFFD);
      check("div_hi_const", md_if.HiE, 32'hFFFF_FFFF);
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("divovf_lo_const", md_if.LoE, 32'h8000_0000);
      check("divovf_hi_const", md_if.HiE, 32'h0000_0000);

      run_op(3'd4, 32'd100, 32'd0, 1'b0);
      check("divu0_lo_const", md_if.LoE, 32'hFFFF_FFFF);
      check("divu0_hi_const", md_if.HiE, 32'h0000_0064);
      run_op(3'd6, 32'h1234_5678, 32'd0, 1'b0);
      check("mtlo_const", md_if.LoE, 32'h1234_5678);

      run_op(3'd1, 32'h0001_0003, 32'hFFFF_0007, 1'b1);
      check("inject_hi_not_aaaa", 32'(md_if.HiE == 32'h0000_AAAA), 32'd0);

      // Abort a divide with reset during its fourth busy cycle.
      md_if.StartE = 1'b1;
      md_if.MdOpE  = 3'd3;
      md_if.SrcAE  = 32'd1000;
      md_if.SrcBE  = 32'd7;
      @(posedge clk);
      @(negedge clk);
      md_if.StartE = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_pre", 32'(md_if.BusyE), 32'd1);
      rst_n = 1'b0;
      #1;
      hi_m = 32'd0;
      lo_m = 32'd0;
      check("abort_busy", 32'(md_if.BusyE), 32'd0);
      check("abort_done", 32'(md_if.DoneE), 32'd0);
      check("abort_hi", md_if.HiE, 32'd0);
      check("abort_lo", md_if.LoE, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (DIV_N + 4) begin
         @(negedge clk);
         if (md_if.DoneE !== 1'b0 || md_if.BusyE !== 1'b0) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      check("abort_hi_after", md_if.HiE, 32'd0);
      $display("op=abort DIV by reset -> HiE=%h LoE=%h", md_if.HiE, md_if.LoE);

      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 4) == 0) rb = 32'd0;
         if ($urandom_range(0, 7) == 0) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         md_if.MfSelE = 1'($urandom_range(0, 1));
         run_op(rop, ra, rb, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Sequencing controller for the multiply/divide resource in the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a fixed-latency multi-cycle operation.
- Owns the architectural HI/LO registers.
- Drives BusyE back to the hazard unit, which stalls any following mult/div-class instruction in ID while StartE or BusyE is high.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..31)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..31)

Ports:
- clk  input  1  pipeline clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- StartE  input  1  EX instruction is a mult/div-class op; qualifies MdOpE
- MdOpE  input  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, others no-op
- SrcAE  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- SrcBE  input  32  rt operand (divisor / multiplier)
- MfSelE  input  1  1 selects HI, 0 selects LO onto MdResultE (MFHI/MFLO)
- BusyE  output  1  operation in flight
- DoneE  output  1  one-cycle pulse in the commit cycle
- HiE  output  32  committed HI
- LoE  output  32  committed LO
- MdResultE  output  32  MfSelE ? HiE : LoE (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, counter 0, pending HI/LO 0.
  - HiE=0, LoE=0, BusyE=0, DoneE=0, MdResultE=0.
  - Reset asserted mid-operation aborts the operation; no commit occurs.
- States: IDLE, RUN, COMMIT.
- IDLE:
  - StartE=1 with a MULT/MULTU/DIV/DIVU op at edge T:
    - capture the full 64-bit result into pending regs.
    - load counter with N-1, where N = MUL_CYCLES or DIV_CYCLES.
    - go to RUN.
  - StartE=1 with MTHI/MTLO: write SrcAE into HI/LO at that edge; no busy; stay IDLE.
  - StartE=1 with a no-op code: ignored.
- RUN:
  - BusyE=1.
  - counter decrements each cycle; at counter 0 go to COMMIT.
  - Busy cycles: BusyE is high for exactly N cycles, T+1..T+N (counting COMMIT).
- COMMIT (cycle T+N):
  - BusyE=1, DoneE=1.
  - pending values written to HI/LO at the end of the cycle; go to IDLE.
  - HiE/LoE show new values from cycle T+N+1, when BusyE=0.
- N=1: RUN is skipped; IDLE -> COMMIT directly.
- Outputs: BusyE and DoneE are registered, decoded from state. HiE/LoE are register outputs.
- StartE while state != IDLE (protocol violation; the hazard unit prevents it):
  - ignored, including MTHI/MTLO.
  - in-flight operation and HI/LO unaffected.
- MULT: signed 32x32 -> 64; HI = bits 63:32, LO = bits 31:0.
- MULTU: unsigned 32x32 -> 64, same HI/LO split.
- DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=SrcAE; latency unchanged.
- Operands are sampled only at the start edge; later changes on SrcAE/SrcBE have no effect.
- Pending result computation is free to be iterative (shift-add / restoring) within N cycles or single-shot; the externally visible timing is fixed as above.

Test Plan:
- Reset, then MULT 0xFFFFFFFE x 0x00000003 -> BusyE high 5 cycles, DoneE pulses at cycle 5, then HiE=0xFFFFFFFF, LoE=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HiE=0xFFFFFFFE, LoE=0x00000001. MfSelE toggling gives MdResultE = HiE, then LoE.
- DIV 0xFFFFFFF9 / 0x00000002 (-7/2) -> BusyE high 10 cycles, LoE=0xFFFFFFFD, HiE=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LoE=0x80000000, HiE=0.
- DIVU 100 / 0 -> LoE=0xFFFFFFFF, HiE=0x00000064. Then MTLO 0x12345678 -> LoE=0x12345678 next cycle with BusyE never asserted.
- MULT started, then StartE DIVU and MTHI 0xAAAA during busy cycles 2-3 -> both ignored, MULT result commits on schedule, HiE is not 0xAAAA.
- DIV started, rst_n pulled low at busy cycle 4 -> immediately BusyE=0, HiE=LoE=0. After release, DoneE never pulses for the aborted op.
